// File: rtl/pkt_stats.sv
// pkt_stats: pass-through statistics stage.
// Forwards {ctrl,data} words through a 2-entry skid buffer. It also tracks
// packet framing and keeps saturating packet, word, runt and max-length counters.
// Optional feature macro: PKT_STATS_ERR_EN. When it is defined, a ctrl==0 word
// accepted in IDLE increments err_count. When it is undefined, err_count is tied to 0.
// fsm_state is a debug view of the framing FSM: 0 = IDLE, 1 = BODY.
//
// Handshake: a word transfers into the block on a rising edge where
// in_wr & in_rdy. It transfers out on a rising edge where out_wr is high;
// out_wr already includes out_rdy. in_rdy depends only on registered state.
// in_wr while in_rdy=0 is ignored.
module pkt_stats #(
   parameter int DATA_WIDTH    = 64,
   parameter int CTRL_WIDTH    = DATA_WIDTH/8,
   parameter int CNT_WIDTH     = 32,
   parameter int LEN_WIDTH     = 16,
   parameter int MIN_PKT_WORDS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic                  stats_clr,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic [CNT_WIDTH-1:0]  runt_count,
   output logic [LEN_WIDTH-1:0]  max_pkt_words,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic                  fsm_state
);

   typedef enum logic {S_IDLE = 1'b0, S_BODY = 1'b1} state_t;

   function automatic logic [CNT_WIDTH-1:0] inc_cnt(input logic [CNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + CNT_WIDTH'(1);
   endfunction

   function automatic logic [LEN_WIDTH-1:0] inc_len(input logic [LEN_WIDTH-1:0] v);
      return (v == '1) ? v : v + LEN_WIDTH'(1);
   endfunction

   logic [DATA_WIDTH-1:0] buf_data [2];
   logic [CTRL_WIDTH-1:0] buf_ctrl [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic                  rdy_en;
   logic                  accept;
   logic                  drain;

   state_t                state;
   state_t                state_nxt;
   logic [LEN_WIDTH-1:0]  pkt_len;
   logic [LEN_WIDTH-1:0]  pkt_len_nxt;
   logic                  pkt_done;
   logic [LEN_WIDTH-1:0]  done_len;
   logic                  is_runt;

   // rdy_en keeps in_rdy low while reset is held and for the first edge after release.
   assign in_rdy   = rdy_en & (count != 2'd2);
   assign accept   = in_wr & in_rdy;
   assign out_wr   = (count != 2'd0) & out_rdy;
   assign drain    = out_wr;
   assign out_data = buf_data[rd_ptr];
   assign out_ctrl = buf_ctrl[rd_ptr];

   // Buffer occupancy and pointers; a simultaneous accept and drain leaves count unchanged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (accept) wr_ptr <= ~wr_ptr;
         if (drain)  rd_ptr <= ~rd_ptr;
         case ({accept, drain})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Buffer storage; an entry is only read while count marks it valid
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_data[wr_ptr] <= in_data;
         buf_ctrl[wr_ptr] <= in_ctrl;
      end
   end

   // Framing state and current packet length
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         pkt_len <= '0;
      end else begin
         state   <= state_nxt;
         pkt_len <= pkt_len_nxt;
      end
   end

   // Framing next-state: header opens a packet, the next nonzero ctrl closes it
   always_comb begin
      state_nxt   = state;
      pkt_len_nxt = pkt_len;
      pkt_done    = 1'b0;
      done_len    = '0;
      if (accept) begin
         case (state)
            S_IDLE: begin
               if (in_ctrl != '0) begin
                  state_nxt   = S_BODY;
                  pkt_len_nxt = LEN_WIDTH'(1);
               end
            end
            S_BODY: begin
               if (in_ctrl == '0) begin
                  pkt_len_nxt = inc_len(pkt_len);
               end else begin
                  state_nxt   = S_IDLE;
                  pkt_done    = 1'b1;
                  done_len    = inc_len(pkt_len);
                  pkt_len_nxt = '0;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign is_runt   = (done_len < LEN_WIDTH'(MIN_PKT_WORDS));
   assign fsm_state = (state == S_BODY);

   // Saturating statistics; clear wins over any same-cycle increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pkt_count     <= '0;
         word_count    <= '0;
         runt_count    <= '0;
         max_pkt_words <= '0;
      end else if (stats_clr) begin
         pkt_count     <= '0;
         word_count    <= '0;
         runt_count    <= '0;
         max_pkt_words <= '0;
      end else begin
         if (accept) word_count <= inc_cnt(word_count);
         if (pkt_done) begin
            pkt_count <= inc_cnt(pkt_count);
            if (is_runt) runt_count <= inc_cnt(runt_count);
            if (done_len > max_pkt_words) max_pkt_words <= done_len;
         end
      end
   end

`ifdef PKT_STATS_ERR_EN
   logic                 stray;
   logic [CNT_WIDTH-1:0] err_q;

   assign stray     = accept & (state == S_IDLE) & (in_ctrl == '0);
   assign err_count = err_q;

   // Framing error counter: ctrl==0 words that arrive outside a packet
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         err_q <= '0;
      else if (stats_clr) err_q <= '0;
      else if (stray)     err_q <= inc_cnt(err_q);
   end
`else
   assign err_count = '0;
`endif

endmodule
